ame_num_compute_pipe: RTL and testbench
=======================================

# ame_num_compute_pipe

Pipelined, multi-lane successor of the affine motion estimation numerator unit. Each lane computes a signed M·D ∓ L·C (or passes D through) at full product precision, then wraps or saturates the result to the data width and flags overflow. The block sits between the AME parameter gatherer and the divider stage. It accepts one multi-lane operand set per cycle and carries a valid/ready handshake with backpressure on both sides.

## Interface
- COMP_DATA_BITS, 64, operand and result width per lane (two's complement, ≥ 8)
- COMP_LANES, 4, independent lanes per transaction
- COMP_TAG_BITS, 4, width of the sideband tag carried alongside each transaction (≥ 1)
- COMP_SAT, 1, 1 = saturate result to signed range; 0 = wrap (keep low COMP_DATA_BITS)

- clk_i  input  1  clock; all state updates on the rising edge
- rst_n_i  input  1  asynchronous active-low reset
- comp_init_i  input  1  input valid
- comp_ready_o  output  1  input ready; a transfer occurs when comp_init_i && comp_ready_o
- comp_mode_i  input  2  00: M·D−L·C; 01: M·D+L·C; 10: pass D; 11: reserved, treated as 00
- comp_tag_i  input  COMP_TAG_BITS  sideband tag, returned unchanged with the result
- comp_data_i  input  COMP_LANES×4×COMP_DATA_BITS  per lane [3:0] = {M, D, L, C}
- comp_done_o  output  1  output valid
- comp_ready_i  input  1  downstream ready; output transfer when comp_done_o && comp_ready_i
- comp_tag_o  output  COMP_TAG_BITS  tag of the presented result
- comp_data_o  output  COMP_LANES×COMP_DATA_BITS  per-lane result
- comp_ovf_o  output  COMP_LANES  per-lane overflow flag

## Operation
- Three registered stages, each holding a valid bit, tag, mode and per-lane payload:
  - S1: operands.
  - S2: the two 2W-bit signed products per lane (W = COMP_DATA_BITS), or D sign-extended for pass mode.
  - S3: final result, overflow flags and tag. S3 drives the outputs directly.
- Stage advance rule, with k = 1..3 and S4 = downstream:
  - adv3 = !v3 || comp_ready_i.
  - advk = !vk || adv(k+1).
  - comp_ready_o = adv1.
  - Bubbles collapse; a stage captures only when advk is set.
- Sum: computed in S3 at 2W+1 bits signed.
  - P = MD − LC for mode 00/11.
  - P = MD + LC for mode 01.
  - P = D for mode 10.
- Overflow: ovf = 1 when P lies outside [−2^(W−1), 2^(W−1)−1]. Pass mode always gives ovf = 0.
- Result:
  - COMP_SAT=1: clamp to the signed limit.
  - COMP_SAT=0: low W bits of P.
  - ovf is reported in both cases.
- Lanes are fully independent; the tag and mode are shared per transaction.
- Ordering is strictly in order. Nothing is dropped or duplicated under any backpressure pattern.

## Timing
- Reset (async assert, sync release): all valid bits 0; S1–S3 payloads and tags 0.
  - During reset: comp_done_o=0, comp_data_o=0, comp_ovf_o=0, comp_tag_o=0.
  - comp_ready_o=1 from the first cycle after release.
- Latency: an input transferred in cycle 0 presents comp_done_o=1 in cycle 3 if no stall.
- Throughput: one transaction per cycle while comp_ready_i=1.
- Output hold: while comp_done_o=1 and comp_ready_i=0, comp_data_o, comp_ovf_o and comp_tag_o hold stable.
- comp_ready_o is combinational from comp_ready_i and the valid bits. No path exists from comp_init_i to comp_ready_o.
- Full pipe with comp_ready_i=0: comp_ready_o=0. If comp_ready_i rises in the same cycle, comp_ready_o=1 that cycle, so a simultaneous accept and drain is a full-rate transfer.
- Empty pipe: comp_done_o=0 and the outputs keep their last value.
- Reset mid-operation discards all in-flight transactions immediately. The outputs follow the reset values above.

## Test plan
Bench uses COMP_DATA_BITS=16, COMP_LANES=2, COMP_TAG_BITS=4.
- Basic difference: mode 00, lane0 {M,D,L,C}={3,5,2,4}, lane1 {−2,3,4,5}, tag 5 → cycle 3: done=1, lane0=7, lane1=−26 (0xFFE6), ovf=00, tag=5.
- Sum and pass: mode 01, lane0 {1,1,−3,7} → −20 (0xFFEC). Then mode 10, lane0 D=0x8001 → 0x8001, ovf=0.
- Saturation and wrap: lane0 {300,300,0,0}.
  - COMP_SAT=1 → 0x7FFF, ovf=1.
  - COMP_SAT=0 → 0x5F90, ovf=1.
  - lane1 {−300,300,0,0} with COMP_SAT=1 → 0x8000, ovf=1.
- Backpressure: tags 0..5 offered back-to-back with comp_ready_i=0 from cycle 0 → tags 0–2 accepted and comp_ready_o=0 in cycle 3, with tag 0 held on the outputs. After comp_ready_i=1, tags 0..5 emerge in order with no loss or duplication.
- Random stall stress: 1000 random transactions with random comp_init_i / comp_ready_i toggling → scoreboard matches a 2W+1-bit reference model and tags appear in order.
- Mid-operation reset: assert rst_n_i=0 for 1 cycle with 3 transactions in flight → outputs 0 and done=0 immediately. No stale result appears after release; the next input returns its result 3 cycles later.

Source files
------------

// File: rtl/ame_num_compute_pipe_if.sv
// Handshake/bus bundle for ame_num_compute_pipe.
// slave  : pipeline view (consumes operands, produces results)
// master : upstream/downstream view (drives operands and downstream ready)
// Signals:
//   comp_init_i / comp_ready_o : input valid / ready
//   comp_mode_i, comp_tag_i, comp_data_i : operand set ({M,D,L,C} per lane)
//   comp_done_o / comp_ready_i : output valid / downstream ready
//   comp_tag_o, comp_data_o, comp_ovf_o : result, per-lane overflow
interface ame_num_compute_pipe_if #(
  parameter int COMP_DATA_BITS = 64,
  parameter int COMP_LANES     = 4,
  parameter int COMP_TAG_BITS  = 4
);
  logic                                  comp_init_i;
  logic                                  comp_ready_o;
  logic [1:0]                            comp_mode_i;
  logic [COMP_TAG_BITS-1:0]              comp_tag_i;
  logic [COMP_LANES*4*COMP_DATA_BITS-1:0] comp_data_i;
  logic                                  comp_done_o;
  logic                                  comp_ready_i;
  logic [COMP_TAG_BITS-1:0]              comp_tag_o;
  logic [COMP_LANES*COMP_DATA_BITS-1:0]  comp_data_o;
  logic [COMP_LANES-1:0]                 comp_ovf_o;

  modport slave (
    input  comp_init_i, comp_mode_i, comp_tag_i, comp_data_i, comp_ready_i,
    output comp_ready_o, comp_done_o, comp_tag_o, comp_data_o, comp_ovf_o
  );

  modport master (
    output comp_init_i, comp_mode_i, comp_tag_i, comp_data_i, comp_ready_i,
    input  comp_ready_o, comp_done_o, comp_tag_o, comp_data_o, comp_ovf_o
  );
endinterface

// File: rtl/ame_num_compute_pipe.sv
// Three-stage multi-lane AME numerator pipeline: per lane M*D -/+ L*C (or pass D)
// at full precision, then saturate or wrap to COMP_DATA_BITS with an overflow flag.
// Ports:
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   comp    : handshake bundle (slave modport), see ame_num_compute_pipe_if
module ame_num_compute_pipe #(
  parameter int COMP_DATA_BITS = 64,
  parameter int COMP_LANES     = 4,
  parameter int COMP_TAG_BITS  = 4,
  parameter int COMP_SAT       = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  ame_num_compute_pipe_if.slave  comp
);
  localparam int W  = COMP_DATA_BITS;
  localparam int LN = COMP_LANES;
  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 1;

  localparam logic signed [SW-1:0] SUM_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0] RES_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] RES_MIN = {1'b1, {(W-1){1'b0}}};

  // Operands are sign-extended to the product width first, so the low 2W bits
  // of the unsigned multiply equal the signed product.
  function automatic logic [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = {{W{a[W-1]}}, a};
    bx = {{W{b[W-1]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [SW-1:0] lane_sum(input logic [PW-1:0] md, input logic [PW-1:0] lc,
                                             input logic sub);
    logic [SW-1:0] mx;
    logic [SW-1:0] lx;
    mx = {md[PW-1], md};
    lx = {lc[PW-1], lc};
    return sub ? (mx - lx) : (mx + lx);
  endfunction

  logic                   v1, v2, v3;
  logic                   adv1, adv2, adv3;
  logic [COMP_TAG_BITS-1:0] tag1, tag2, tag3;
  logic [1:0]             mode1, mode2;
  logic [LN*4*W-1:0]      ops1;
  logic [LN*PW-1:0]       md2, lc2;
  logic [LN*W-1:0]        res3;
  logic [LN-1:0]          ovf3;

  logic [LN*PW-1:0]       md_c, lc_c;
  logic [LN*SW-1:0]       sum_c;
  logic [LN*W-1:0]        res_c;
  logic [LN-1:0]          ovf_c;

  assign adv3 = !v3 || comp.comp_ready_i;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;
  assign comp.comp_ready_o = adv1;

  // S1 -> S2: products; pass mode carries sign-extended D with a zero second term
  always_comb begin
    md_c = '0;
    lc_c = '0;
    for (int l = 0; l < LN; l++) begin
      if (mode1 == 2'b10) begin
        md_c[l*PW +: PW] = {{W{ops1[(4*l+3)*W-1]}}, ops1[(4*l+2)*W +: W]};
      end else begin
        md_c[l*PW +: PW] = smul(ops1[(4*l+3)*W +: W], ops1[(4*l+2)*W +: W]);
        lc_c[l*PW +: PW] = smul(ops1[(4*l+1)*W +: W], ops1[(4*l)*W +: W]);
      end
    end
  end

  // S2 -> S3: sum, range check, saturate or wrap
  always_comb begin
    sum_c = '0;
    res_c = '0;
    ovf_c = '0;
    for (int l = 0; l < LN; l++) begin
      sum_c[l*SW +: SW] = lane_sum(md2[l*PW +: PW], lc2[l*PW +: PW], mode2 != 2'b01);
      ovf_c[l] = ($signed(sum_c[l*SW +: SW]) > SUM_MAX) ||
                 ($signed(sum_c[l*SW +: SW]) < SUM_MIN);
      if ((COMP_SAT != 0) && ovf_c[l]) begin
        res_c[l*W +: W] = sum_c[l*SW + SW - 1] ? RES_MIN : RES_MAX;
      end else begin
        res_c[l*W +: W] = sum_c[l*SW +: W];
      end
    end
  end

  // Payloads load only with valid data so an emptied stage keeps its last value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      tag1  <= '0;
      tag2  <= '0;
      tag3  <= '0;
      mode1 <= '0;
      mode2 <= '0;
      ops1  <= '0;
      md2   <= '0;
      lc2   <= '0;
      res3  <= '0;
      ovf3  <= '0;
    end else begin
      if (adv1) begin
        v1 <= comp.comp_init_i;
        if (comp.comp_init_i) begin
          tag1  <= comp.comp_tag_i;
          mode1 <= comp.comp_mode_i;
          ops1  <= comp.comp_data_i;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          tag2  <= tag1;
          mode2 <= mode1;
          md2   <= md_c;
          lc2   <= lc_c;
        end
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          tag3 <= tag2;
          res3 <= res_c;
          ovf3 <= ovf_c;
        end
      end
    end
  end

  assign comp.comp_done_o = v3;
  assign comp.comp_tag_o  = tag3;
  assign comp.comp_data_o = res3;
  assign comp.comp_ovf_o  = ovf3;
endmodule

// File: tb/tb_ame_num_compute_pipe.sv
module tb_ame_num_compute_pipe;
  localparam int W  = 16;
  localparam int LN = 2;
  localparam int TB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ame_num_compute_pipe_if #(.COMP_DATA_BITS(W), .COMP_LANES(LN), .COMP_TAG_BITS(TB)) ifs ();
  ame_num_compute_pipe_if #(.COMP_DATA_BITS(W), .COMP_LANES(LN), .COMP_TAG_BITS(TB)) ifw ();

  assign ifw.comp_init_i  = ifs.comp_init_i;
  assign ifw.comp_mode_i  = ifs.comp_mode_i;
  assign ifw.comp_tag_i   = ifs.comp_tag_i;
  assign ifw.comp_data_i  = ifs.comp_data_i;
  assign ifw.comp_ready_i = ifs.comp_ready_i;

  ame_num_compute_pipe #(.COMP_DATA_BITS(W), .COMP_LANES(LN), .COMP_TAG_BITS(TB), .COMP_SAT(1))
    dut_sat (.clk_i(clk), .rst_n_i(rst_n), .comp(ifs));
  ame_num_compute_pipe #(.COMP_DATA_BITS(W), .COMP_LANES(LN), .COMP_TAG_BITS(TB), .COMP_SAT(0))
    dut_wrap (.clk_i(clk), .rst_n_i(rst_n), .comp(ifw));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] ds;
    logic [31:0] dw;
    logic [1:0]  ovf;
  } exp_t;
  exp_t q[$];

  function automatic logic [63:0] lane(input logic [15:0] m, input logic [15:0] d,
                                       input logic [15:0] l, input logic [15:0] c);
    return {m, d, l, c};
  endfunction

  function automatic void model(input logic [1:0] mode, input logic [63:0] ln,
                                output logic [15:0] rs, output logic [15:0] rw,
                                output logic ov);
    longint m, d, l, c, p;
    m = longint'($signed(ln[63:48]));
    d = longint'($signed(ln[47:32]));
    l = longint'($signed(ln[31:16]));
    c = longint'($signed(ln[15:0]));
    if (mode == 2'b10)      p = d;
    else if (mode == 2'b01) p = m * d + l * c;
    else                    p = m * d - l * c;
    ov = (p > 32767) || (p < -32768);
    rw = p[15:0];
    rs = ov ? ((p < 0) ? 16'h8000 : 16'h7FFF) : p[15:0];
  endfunction

  // Called just after a rising edge with an empty, non-stalled pipe; returns at
  // the falling edge of the cycle in which the result should be presented.
  task automatic send_one(input logic [1:0] mode, input logic [3:0] tag, input logic [127:0] data);
    ifs.comp_mode_i = mode;
    ifs.comp_tag_i  = tag;
    ifs.comp_data_i = data;
    ifs.comp_init_i = 1'b1;
    @(posedge clk); #1;
    ifs.comp_init_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    ifs.comp_init_i  = 1'b0;
    ifs.comp_mode_i  = 2'b00;
    ifs.comp_tag_i   = '0;
    ifs.comp_data_i  = '0;
    ifs.comp_ready_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++;
    if ({ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o} !== '0) begin
      errors++;
      $display("FAIL reset_sat: got done=%b data=%h ovf=%b tag=%h want all zero",
               ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o);
    end
    checks++;
    if ({ifw.comp_done_o, ifw.comp_data_o, ifw.comp_ovf_o, ifw.comp_tag_o} !== '0) begin
      errors++;
      $display("FAIL reset_wrap: got done=%b data=%h ovf=%b tag=%h want all zero",
               ifw.comp_done_o, ifw.comp_data_o, ifw.comp_ovf_o, ifw.comp_tag_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ifs.comp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", ifs.comp_ready_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    ifs.comp_ready_i = 1'b1;
    ifs.comp_mode_i  = 2'b00;
    ifs.comp_tag_i   = 4'd5;
    ifs.comp_data_i  = {lane(16'hFFFE, 16'd3, 16'd4, 16'd5), lane(16'd3, 16'd5, 16'd2, 16'd4)};
    ifs.comp_init_i  = 1'b1;
    @(posedge clk); #1;
    ifs.comp_init_i = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ifs.comp_done_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_done: got %b want 0 in cycle 2", ifs.comp_done_o);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o} !==
        {1'b1, 32'hFFE6_0007, 2'b00, 4'd5}) begin
      errors++;
      $display("FAIL basic_diff: got done=%b data=%h ovf=%b tag=%h want done=1 data=ffe60007 ovf=00 tag=5",
               ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sum_pass();
    send_one(2'b01, 4'd1, {lane(16'd0, 16'd0, 16'd0, 16'd0), lane(16'd1, 16'd1, 16'hFFFD, 16'd7)});
    checks++;
    if ({ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o} !==
        {1'b1, 32'h0000_FFEC, 2'b00, 4'd1}) begin
      errors++;
      $display("FAIL sum_mode01: got done=%b data=%h ovf=%b tag=%h want 1 0000ffec 00 1",
               ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o);
    end
    @(posedge clk); #1;
    send_one(2'b10, 4'd2, {lane(16'd9, 16'h7FFF, 16'd9, 16'd9), lane(16'd5, 16'h8001, 16'd7, 16'd9)});
    checks++;
    if ({ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o} !==
        {1'b1, 32'h7FFF_8001, 2'b00, 4'd2}) begin
      errors++;
      $display("FAIL pass_sat: got done=%b data=%h ovf=%b tag=%h want 1 7fff8001 00 2",
               ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o);
    end
    checks++;
    if ({ifw.comp_data_o, ifw.comp_ovf_o} !== {32'h7FFF_8001, 2'b00}) begin
      errors++;
      $display("FAIL pass_wrap: got data=%h ovf=%b want 7fff8001 00", ifw.comp_data_o, ifw.comp_ovf_o);
    end
    @(posedge clk); #1;
    send_one(2'b11, 4'd3, {lane(16'hFFFE, 16'd3, 16'd4, 16'd5), lane(16'd3, 16'd5, 16'd2, 16'd4)});
    checks++;
    if ({ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o} !== {32'hFFE6_0007, 2'b00, 4'd3}) begin
      errors++;
      $display("FAIL mode11_as_00: got data=%h ovf=%b tag=%h want ffe60007 00 3",
               ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sat_wrap();
    send_one(2'b00, 4'd4, {lane(16'hFED4, 16'h012C, 16'd0, 16'd0), lane(16'h012C, 16'h012C, 16'd0, 16'd0)});
    checks++;
    if ({ifs.comp_data_o, ifs.comp_ovf_o} !== {32'h8000_7FFF, 2'b11}) begin
      errors++;
      $display("FAIL sat_300: got data=%h ovf=%b want 80007fff 11", ifs.comp_data_o, ifs.comp_ovf_o);
    end
    checks++;
    if ({ifw.comp_data_o, ifw.comp_ovf_o} !== {32'hA070_5F90, 2'b11}) begin
      errors++;
      $display("FAIL wrap_300: got data=%h ovf=%b want a0705f90 11", ifw.comp_data_o, ifw.comp_ovf_o);
    end
    @(posedge clk); #1;
    send_one(2'b00, 4'd6, {lane(16'h8000, 16'd1, 16'd1, 16'd1), lane(16'h7FFF, 16'd1, 16'd0, 16'd0)});
    checks++;
    if ({ifs.comp_data_o, ifs.comp_ovf_o} !== {32'h8000_7FFF, 2'b10}) begin
      errors++;
      $display("FAIL sat_edge_sub: got data=%h ovf=%b want 80007fff 10", ifs.comp_data_o, ifs.comp_ovf_o);
    end
    checks++;
    if ({ifw.comp_data_o, ifw.comp_ovf_o} !== {32'h7FFF_7FFF, 2'b10}) begin
      errors++;
      $display("FAIL wrap_edge_sub: got data=%h ovf=%b want 7fff7fff 10", ifw.comp_data_o, ifw.comp_ovf_o);
    end
    @(posedge clk); #1;
    send_one(2'b01, 4'd7, {lane(16'h8000, 16'd1, 16'd0, 16'd0), lane(16'h7FFF, 16'd1, 16'd1, 16'd1)});
    checks++;
    if ({ifs.comp_data_o, ifs.comp_ovf_o} !== {32'h8000_7FFF, 2'b01}) begin
      errors++;
      $display("FAIL sat_edge_add: got data=%h ovf=%b want 80007fff 01", ifs.comp_data_o, ifs.comp_ovf_o);
    end
    checks++;
    if ({ifw.comp_data_o, ifw.comp_ovf_o} !== {32'h8000_8000, 2'b01}) begin
      errors++;
      $display("FAIL wrap_edge_add: got data=%h ovf=%b want 80008000 01", ifw.comp_data_o, ifw.comp_ovf_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int got = 0;
    ifs.comp_ready_i = 1'b0;
    ifs.comp_mode_i  = 2'b00;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc == 6) ifs.comp_ready_i = 1'b1;
      ifs.comp_init_i = (idx < 6);
      ifs.comp_tag_i  = idx[3:0];
      ifs.comp_data_i = {lane(16'd0, 16'd0, 16'd0, 16'd0), lane(16'(idx + 1), 16'd1, 16'd0, 16'd0)};
      @(negedge clk);
      if (cyc == 3) begin
        checks++;
        if ({ifs.comp_ready_o, ifs.comp_done_o, ifs.comp_tag_o, ifs.comp_data_o} !==
            {1'b0, 1'b1, 4'd0, 32'h0000_0001} || idx != 3) begin
          errors++;
          $display("FAIL bp_full: got ready=%b done=%b tag=%h data=%h accepted=%0d want 0 1 0 00000001 3",
                   ifs.comp_ready_o, ifs.comp_done_o, ifs.comp_tag_o, ifs.comp_data_o, idx);
        end
      end
      if (cyc == 5) begin
        checks++;
        if ({ifs.comp_done_o, ifs.comp_tag_o, ifs.comp_data_o, ifs.comp_ovf_o} !==
            {1'b1, 4'd0, 32'h0000_0001, 2'b00}) begin
          errors++;
          $display("FAIL bp_hold: got done=%b tag=%h data=%h ovf=%b want 1 0 00000001 00",
                   ifs.comp_done_o, ifs.comp_tag_o, ifs.comp_data_o, ifs.comp_ovf_o);
        end
      end
      if (ifs.comp_done_o && ifs.comp_ready_i) begin
        checks++;
        if ({ifs.comp_tag_o, ifs.comp_data_o} !== {4'(got), 16'd0, 16'(got + 1)}) begin
          errors++;
          $display("FAIL bp_order: got tag=%h data=%h want tag=%h data=%h",
                   ifs.comp_tag_o, ifs.comp_data_o, got[3:0], 32'(got + 1));
        end
        got++;
      end
      if (ifs.comp_init_i && ifs.comp_ready_o) idx++;
      @(posedge clk); #1;
    end
    ifs.comp_init_i = 1'b0;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d results want 6", got);
    end
  endtask

  task automatic test_random();
    int idx = 0;
    int got = 0;
    int cyc = 0;
    logic have = 1'b0;
    logic [1:0] mode;
    logic [127:0] data;
    logic [15:0] rs0, rw0, rs1, rw1;
    logic o0, o1;
    exp_t e;
    q.delete();
    while (got < 1000 && cyc < 20000) begin
      if (!have && idx < 1000) begin
        mode = 2'($urandom_range(0, 3));
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        have = 1'b1;
      end
      ifs.comp_mode_i  = mode;
      ifs.comp_tag_i   = idx[3:0];
      ifs.comp_data_i  = data;
      ifs.comp_init_i  = have && ($urandom_range(0, 3) != 0);
      ifs.comp_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (ifs.comp_done_o && ifs.comp_ready_i) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra: got unexpected result tag=%h", ifs.comp_tag_o);
        end else begin
          e = q.pop_front();
          if ({ifs.comp_tag_o, ifs.comp_data_o, ifs.comp_ovf_o} !== {e.tag, e.ds, e.ovf} ||
              {ifw.comp_done_o, ifw.comp_tag_o, ifw.comp_data_o, ifw.comp_ovf_o} !==
              {1'b1, e.tag, e.dw, e.ovf}) begin
            errors++;
            $display("FAIL rnd_result %0d: got tag=%h sat=%h wrap=%h ovf=%b/%b want tag=%h sat=%h wrap=%h ovf=%b",
                     got, ifs.comp_tag_o, ifs.comp_data_o, ifw.comp_data_o, ifs.comp_ovf_o,
                     ifw.comp_ovf_o, e.tag, e.ds, e.dw, e.ovf);
          end
        end
        got++;
      end
      if (ifs.comp_init_i && ifs.comp_ready_o) begin
        model(mode, data[63:0], rs0, rw0, o0);
        model(mode, data[127:64], rs1, rw1, o1);
        e.tag = idx[3:0];
        e.ds  = {rs1, rs0};
        e.dw  = {rw1, rw0};
        e.ovf = {o1, o0};
        q.push_back(e);
        have = 1'b0;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ifs.comp_init_i  = 1'b0;
    ifs.comp_ready_i = 1'b1;
    checks++;
    if (got != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL rnd_count: got %0d results, %0d pending, want 1000 and 0", got, q.size());
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    int stale = 0;
    ifs.comp_ready_i = 1'b0;
    ifs.comp_mode_i  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      ifs.comp_init_i = 1'b1;
      ifs.comp_tag_i  = 4'(10 + i);
      ifs.comp_data_i = {lane(16'd1, 16'd1, 16'd0, 16'd0), lane(16'd2, 16'd2, 16'd0, 16'd0)};
      @(posedge clk); #1;
    end
    ifs.comp_init_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o} !== '0) begin
      errors++;
      $display("FAIL midrst_sat: got done=%b data=%h ovf=%b tag=%h want all zero",
               ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o);
    end
    checks++;
    if ({ifw.comp_done_o, ifw.comp_data_o, ifw.comp_ovf_o, ifw.comp_tag_o} !== '0) begin
      errors++;
      $display("FAIL midrst_wrap: got done=%b data=%h ovf=%b tag=%h want all zero",
               ifw.comp_done_o, ifw.comp_data_o, ifw.comp_ovf_o, ifw.comp_tag_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ifs.comp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifs.comp_done_o !== 1'b0) stale++;
      @(posedge clk); #1;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL midrst_stale: got %0d cycles with done=1 want 0", stale);
    end
    send_one(2'b00, 4'd9, {lane(16'hFFFE, 16'd3, 16'd4, 16'd5), lane(16'd3, 16'd5, 16'd2, 16'd4)});
    checks++;
    if ({ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o} !==
        {1'b1, 32'hFFE6_0007, 2'b00, 4'd9}) begin
      errors++;
      $display("FAIL midrst_next: got done=%b data=%h ovf=%b tag=%h want 1 ffe60007 00 9",
               ifs.comp_done_o, ifs.comp_data_o, ifs.comp_ovf_o, ifs.comp_tag_o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sum_pass();
    test_sat_wrap();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
